// File: rtl/i2s_frame_ctrl.sv
// rtl/i2s_frame_ctrl.sv - I2S master frame controller with Tx prefetch and Rx word assembly
// Optional feature macro: I2S_ERR_FLAGS_EN enables the sticky tx_underrun/rx_overrun flags.
module i2s_frame_ctrl (
  input  logic        pclk,
  input  logic        preset,
  input  logic        ctrl_en,
  input  logic [7:0]  clk_div,
  input  logic [1:0]  word_len,
  input  logic        tx_en,
  input  logic        rx_en,
  input  logic        Tx_empty,
  input  logic [31:0] Tx_rdata,
  output logic        Tx_ren,
  input  logic        Rx_full,
  output logic        Rx_wen,
  output logic [31:0] Rx_wdata,
  input  logic        sd_in,
  output logic        sck,
  output logic        ws,
  output logic        sd_out,
  output logic        busy,
  input  logic        clr_err,
  output logic        tx_underrun,
  output logic        rx_overrun
);

  typedef enum logic [1:0] {S_IDLE, S_PREFETCH, S_RUN, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_cfg_q, div_cfg_d;
  logic [1:0]  wl_cfg_q, wl_cfg_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        pf_cnt_q, pf_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        slot_q, slot_d;
  logic        sck_q, sck_d;
  logic        ws_q, ws_d;
  logic        sd_out_q, sd_out_d;
  logic [31:0] tx_sr_q, tx_sr_d;
  logic [30:0] rx_sr_q, rx_sr_d;
  logic [31:0] pf_q, pf_d;
  logic        pf_valid_q, pf_valid_d;
  logic        pend_q, pend_d;
  logic        tx_ren_q, tx_ren_d;
  logic        rx_wen_q, rx_wen_d;
  logic [31:0] rx_wdata_q, rx_wdata_d;
  logic        busy_q, busy_d;

  logic        under_evt, over_evt;
  logic        slot_start;
  logic [31:0] load_word, aligned;
  logic [4:0]  shamt, last_bit;
  logic [31:0] word_mask;
  logic        tick;

  // slot width N encoded as a left shift of 32-N; the MSB of an N-bit word lands at bit 31
  assign shamt     = {~wl_cfg_q, 3'b000};
  assign last_bit  = 5'd31 - shamt;
  assign word_mask = 32'hFFFF_FFFF >> shamt;
  assign tick      = (div_cnt_q == div_cfg_q);

  // next-state logic for the frame FSM, bit clock, shifters and FIFO strobes
  always_comb begin
    state_d    = state_q;
    div_cfg_d  = div_cfg_q;
    wl_cfg_d   = wl_cfg_q;
    div_cnt_d  = div_cnt_q;
    pf_cnt_d   = pf_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    slot_d     = slot_q;
    sck_d      = sck_q;
    ws_d       = ws_q;
    sd_out_d   = sd_out_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    pf_d       = pf_q;
    pf_valid_d = pf_valid_q;
    tx_ren_d   = 1'b0;
    rx_wen_d   = 1'b0;
    rx_wdata_d = rx_wdata_q;
    under_evt  = 1'b0;
    over_evt   = 1'b0;
    slot_start = 1'b0;
    load_word  = 32'd0;
    aligned    = 32'd0;
    // FIFO read data is valid the cycle after the strobe
    pend_d     = tx_ren_q;

    if (pend_q) begin
      pf_d       = Tx_rdata;
      pf_valid_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        div_cfg_d = clk_div;
        wl_cfg_d  = word_len;
        div_cnt_d = 8'd0;
        pf_cnt_d  = 1'b0;
        bit_cnt_d = 5'd0;
        slot_d    = 1'b0;
        sck_d     = 1'b0;
        ws_d      = 1'b0;
        sd_out_d  = 1'b0;
        tx_sr_d   = 32'd0;
        if (ctrl_en) begin
          state_d  = S_PREFETCH;
          // strobe is visible during the first PREFETCH cycle
          tx_ren_d = tx_en && !Tx_empty;
        end
      end
      S_PREFETCH: begin
        pf_cnt_d = 1'b1;
        if (pf_cnt_q) begin
          // entering RUN acts as the first slot boundary: left MSB goes out with sck low
          state_d    = S_RUN;
          slot_start = 1'b1;
        end
      end
      default: begin
        if (state_q == S_RUN && !ctrl_en) state_d = S_DRAIN;
        if (state_q == S_DRAIN && ctrl_en) state_d = S_RUN;
        if (tick) begin
          div_cnt_d = 8'd0;
          sck_d     = ~sck_q;
          if (!sck_q) begin
            // rising edge: sample, and hand off the word when its LSB arrives
            rx_sr_d = {rx_sr_q[29:0], sd_in};
            if (bit_cnt_q == last_bit && rx_en) begin
              if (Rx_full) begin
                over_evt = 1'b1;
              end else begin
                rx_wen_d   = 1'b1;
                rx_wdata_d = {rx_sr_q, sd_in} & word_mask;
              end
            end
          end else begin
            // falling edge: advance to the next bit or the next slot
            if (bit_cnt_q == last_bit) begin
              if (slot_q && !ctrl_en) begin
                state_d   = S_IDLE;
                bit_cnt_d = 5'd0;
                slot_d    = 1'b0;
                ws_d      = 1'b0;
                sd_out_d  = 1'b0;
                tx_sr_d   = 32'd0;
              end else begin
                slot_start = 1'b1;
                slot_d     = ~slot_q;
                bit_cnt_d  = 5'd0;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
              sd_out_d  = tx_sr_q[31];
              tx_sr_d   = tx_sr_q << 1;
              // ws flips while the LSB is on the wire, one period ahead of the next MSB
              if (bit_cnt_q + 5'd1 == last_bit) ws_d = ~slot_q;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
    endcase

    if (slot_start) begin
      // the word fetched at a right-slot start would belong to a frame that drain never runs
      tx_ren_d = tx_en && !Tx_empty && !(state_d == S_DRAIN && slot_d);
      if (tx_en) begin
        if (pend_q) begin
          load_word = Tx_rdata;
        end else if (pf_valid_q) begin
          load_word = pf_q;
        end else begin
          under_evt = 1'b1;
        end
      end
      aligned    = load_word << shamt;
      sd_out_d   = aligned[31];
      tx_sr_d    = aligned << 1;
      pf_valid_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge pclk) begin
    if (!preset) begin
      state_q    <= S_IDLE;
      div_cfg_q  <= 8'd0;
      wl_cfg_q   <= 2'd0;
      div_cnt_q  <= 8'd0;
      pf_cnt_q   <= 1'b0;
      bit_cnt_q  <= 5'd0;
      slot_q     <= 1'b0;
      sck_q      <= 1'b0;
      ws_q       <= 1'b0;
      sd_out_q   <= 1'b0;
      tx_sr_q    <= 32'd0;
      rx_sr_q    <= 31'd0;
      pf_q       <= 32'd0;
      pf_valid_q <= 1'b0;
      pend_q     <= 1'b0;
      tx_ren_q   <= 1'b0;
      rx_wen_q   <= 1'b0;
      rx_wdata_q <= 32'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cfg_q  <= div_cfg_d;
      wl_cfg_q   <= wl_cfg_d;
      div_cnt_q  <= div_cnt_d;
      pf_cnt_q   <= pf_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      slot_q     <= slot_d;
      sck_q      <= sck_d;
      ws_q       <= ws_d;
      sd_out_q   <= sd_out_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      pf_q       <= pf_d;
      pf_valid_q <= pf_valid_d;
      pend_q     <= pend_d;
      tx_ren_q   <= tx_ren_d;
      rx_wen_q   <= rx_wen_d;
      rx_wdata_q <= rx_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign Tx_ren   = tx_ren_q;
  assign Rx_wen   = rx_wen_q;
  assign Rx_wdata = rx_wdata_q;
  assign sck      = sck_q;
  assign ws       = ws_q;
  assign sd_out   = sd_out_q;
  assign busy     = busy_q;

`ifdef I2S_ERR_FLAGS_EN
  logic under_q, under_d, over_q, over_d;

  // sticky error flags; a new event in the same cycle as clr_err keeps the flag set
  always_comb begin
    under_d = under_evt ? 1'b1 : (clr_err ? 1'b0 : under_q);
    over_d  = over_evt  ? 1'b1 : (clr_err ? 1'b0 : over_q);
  end

  // error flag registers
  always_ff @(posedge pclk) begin
    if (!preset) begin
      under_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      under_q <= under_d;
      over_q  <= over_d;
    end
  end

  assign tx_underrun = under_q;
  assign rx_overrun  = over_q;
`else
  logic unused_err;
  assign unused_err  = &{1'b0, clr_err, under_evt, over_evt};
  assign tx_underrun = 1'b0;
  assign rx_overrun  = 1'b0;
`endif

endmodule
